// File: rtl/seq_pattern_gen.sv
// Purpose : serial pattern generator; shifts out a latched pattern MSB-first (bit len-1 first), reps+1 times.
// Latency : first bit on data one cycle after start is accepted; registered Moore outputs.
// Backpressure: none; start is only sampled in IDLE, and start seen while busy/done is dropped. SEQ_GEN_GAP_EN adds a 1-cycle spacer between repetitions.
module seq_pattern_gen #(
  parameter int WIDTH  = 8,
  parameter int LEN_W  = $clog2(WIDTH + 1),
  parameter int REPS_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  pattern,
  input  logic [LEN_W-1:0]  len,
  input  logic [REPS_W-1:0] reps,
  output logic              data,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef SEQ_GEN_GAP_EN
  localparam logic [1:0] GAP   = 2'd2;
`endif
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  logic [1:0]        state;
  logic [WIDTH-1:0]  pat_q;
  logic [IDX_W-1:0]  last_q;   // L-1, reload value for each repetition
  logic [IDX_W-1:0]  idx_q;    // index of the bit currently on data
  logic [REPS_W-1:0] cnt_q;    // repetitions still to send after this one
  logic [IDX_W-1:0]  start_last;

  // Effective length minus one: a zero or oversized len means the full register.
  always_comb begin
    start_last = IDX_W'(WIDTH - 1);
    if (len != '0 && len <= WIDTH_L) begin
      start_last = IDX_W'(len - LEN_W'(1));
    end
  end

  // State machine with outputs registered from the next state, so each bit lands one cycle after its decision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pat_q  <= '0;
      last_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      data   <= 1'b0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data  <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            pat_q  <= pattern;
            last_q <= start_last;
            idx_q  <= start_last;
            cnt_q  <= reps;
            state  <= SHIFT;
            data   <= pattern[start_last];
            valid  <= 1'b1;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          if (idx_q == '0) begin
            if (cnt_q == '0) begin
              state <= DONE;
              data  <= 1'b0;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - REPS_W'(1);
              idx_q <= last_q;
`ifdef SEQ_GEN_GAP_EN
              state <= GAP;
              data  <= 1'b0;
              valid <= 1'b0;
`else
              data  <= pat_q[last_q];
`endif
            end
          end else begin
            idx_q <= idx_q - IDX_W'(1);
            data  <= pat_q[idx_q - IDX_W'(1)];
          end
        end
`ifdef SEQ_GEN_GAP_EN
        GAP: begin
          // Index was already reloaded on the way in, so resume at the top bit.
          state <= SHIFT;
          data  <= pat_q[idx_q];
          valid <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          data  <= 1'b0;
          valid <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Purpose : scoreboard bench for seq_pattern_gen; expected per-cycle {data,valid,busy,done} queued at stimulus time.
// Latency : monitor samples 2 time units after each rising edge and pops one expected tuple per cycle.
// Backpressure: n/a; an empty queue means the DUT must be idle (all outputs 0).
module tb_seq_pattern_gen;

`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [1:0] reps;
  logic       data, valid, busy, done;

  int tests_run = 0;
  int tests_failed = 0;
  bit mon_en = 1'b0;

  logic [3:0] expq[$];
  logic [3:0] mexp;

  seq_pattern_gen #(.WIDTH(8), .LEN_W(4), .REPS_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .len(len), .reps(reps), .data(data), .valid(valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected stream straight from the behavioural description: L bits MSB-first, reps+1 times, optional gap, then done.
  task automatic push_burst(input logic [7:0] p, input logic [3:0] l, input logic [1:0] r);
    int eff;
    eff = (l == 0 || l > 8) ? 8 : int'(l);
    for (int k = 0; k <= int'(r); k++) begin
      for (int i = eff - 1; i >= 0; i--) expq.push_back({p[i], 3'b110});
      if (GAP_ON && k < int'(r)) expq.push_back(4'b0010);
    end
    expq.push_back(4'b0001);
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge after acceptance.
  task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [1:0] r);
    pattern = p; len = l; reps = r; start = 1'b1;
    push_burst(p, l, r);
    @(negedge clk);
    start = 1'b0;
    pattern = 8'h00; len = 4'd0; reps = 2'd0;
  endtask

  // Wait (bounded) for the queue to drain, then one more negedge so the DUT is back in IDLE.
  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", expq.size(), 0);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    if (mon_en) begin
      #2;
      mexp = (expq.size() != 0) ? expq.pop_front() : 4'b0000;
      chk("stream", {28'd0, data, valid, busy, done}, {28'd0, mexp});
    end
  end

  initial begin
    reset = 1'b0; start = 1'b0; pattern = 8'h00; len = 4'd0; reps = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_data",  data,  0);
    chk("rst_valid", valid, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_done",  done,  0);
    reset = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 3-bit burst
    send(8'b0000_0111, 4'd3, 2'd0);
    drain();
    // Repetitions (gap presence follows the build)
    send(8'b0000_0110, 4'd3, 2'd2);
    drain();
    // Length clamp: 0 and oversize both mean full width
    send(8'hA5, 4'd0, 2'd0);
    drain();
    send(8'hA5, 4'd12, 2'd0);
    drain();
    // Start re-pulsed mid-burst with different inputs must be ignored
    send(8'hA5, 4'd8, 2'd1);
    repeat (2) @(negedge clk);
    pattern = 8'hFF; len = 4'd2; reps = 2'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    // Reset during bit 2 of 8: immediate clear, no done pulse
    send(8'hA5, 4'd8, 2'd0);
    @(negedge clk);
    reset = 1'b0;
    expq.delete();
    #1;
    chk("midrst_data",  data,  0);
    chk("midrst_valid", valid, 0);
    chk("midrst_busy",  busy,  0);
    @(negedge clk);
    chk("midrst_done",  done,  0);
    reset = 1'b1;
    @(negedge clk);
    send(8'hC3, 4'd8, 2'd0);
    drain();
    // Back-to-back with start held: DONE + IDLE between bursts
    pattern = 8'b0000_0010; len = 4'd2; reps = 2'd0; start = 1'b1;
    for (int b = 0; b < 3; b++) begin
      push_burst(8'b0000_0010, 4'd2, 2'd0);
      if (b < 2) expq.push_back(4'b0000);
    end
    begin
      int n;
      n = 0;
      while (expq.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_timeout", expq.size(), 0);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
